// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: finds the left shift that normalizes an operand
// (leading zeros or redundant sign bits) one bit per clock.
module seq_normalizer #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] norm_out,
    output logic [CW-1:0]    lz_count,
    output logic             is_zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LZ_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] LZ_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             mode_r;
    logic [WIDTH-1:0] norm_r;
    logic [CW-1:0]    lz_r;
    logic             is_zero_r;
    logic             busy_r;
    logic             done_r;

    logic             term_s;
    logic             x_zero_s;
    logic             x_ones_s;

    // Terminate when the top bit is significant, or at the shift-count bound.
    always_comb begin
        term_s   = 1'b0;
        x_zero_s = (x == '0);
        x_ones_s = (&x);
        if (mode_r) begin
            term_s = (shift_r[WIDTH-1] != shift_r[WIDTH-2]);
        end else begin
            term_s = shift_r[WIDTH-1];
        end
        if (cnt_r == LZ_LAST) begin
            term_s = 1'b1;
        end else begin
            term_s = term_s;
        end
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            shift_r   <= '0;
            cnt_r     <= '0;
            mode_r    <= 1'b0;
            norm_r    <= '0;
            lz_r      <= '0;
            is_zero_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (start) begin
                        mode_r  <= signed_mode;
                        cnt_r   <= '0;
                        shift_r <= x;
                        // Zero and all-ones operands need no shifting at all.
                        if (x_zero_s) begin
                            norm_r    <= '0;
                            lz_r      <= signed_mode ? LZ_LAST : LZ_FULL;
                            is_zero_r <= 1'b1;
                            done_r    <= 1'b1;
                            state_r   <= S_DONE;
                        end else if (signed_mode && x_ones_s) begin
                            norm_r    <= x;
                            lz_r      <= LZ_LAST;
                            is_zero_r <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= S_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= S_RUN;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (term_s) begin
                        norm_r    <= shift_r;
                        lz_r      <= cnt_r;
                        is_zero_r <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign norm_out = norm_r;
    assign lz_count = lz_r;
    assign is_zero  = is_zero_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer: expected results queued at launch and
// compared when done rises, along with latency and busy duration.
module tb_seq_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] x;
    logic [31:0] norm_out;
    logic [5:0]  lz_count;
    logic        is_zero;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] norm;
        logic [5:0]  lz;
        logic        iz;
        int          edges;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_edges  = 0;
    int   busy_cyc = 0;

    seq_normalizer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .x(x), .norm_out(norm_out), .lz_count(lz_count), .is_zero(is_zero),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_edges++;
        busy_cyc += int'(busy);
    endtask

    task automatic launch(input logic [31:0] xv, input logic m);
        @(negedge clk);
        x = xv;
        signed_mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_edges = 1;
        busy_cyc = int'(busy);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        while (!done && n_edges < 40) step();
        check({tag, "_done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(n_edges), 32'(e.edges));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(e.edges - 1));
        check({tag, "_norm"}, norm_out, e.norm);
        check({tag, "_lz"}, 32'(lz_count), 32'(e.lz));
        check({tag, "_is_zero"}, 32'(is_zero), 32'(e.iz));
    endtask

    task automatic do_op(input string tag, input logic [31:0] xv, input logic m,
                         input logic [31:0] en, input logic [5:0] el, input logic ez,
                         input int edges);
        sb.push_back('{norm: en, lz: el, iz: ez, edges: edges});
        launch(xv, m);
        wait_done(tag);
        step();
        check({tag, "_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        x = 32'd0;
        #12;
        check("rst_norm", norm_out, 32'd0);
        check("rst_lz", 32'(lz_count), 32'd0);
        check("rst_flags", {29'd0, is_zero, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("u_10000", 32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0, 17);
        do_op("u_msb",   32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 2);
        do_op("u_one",   32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0, 33);
        do_op("u_zero",  32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1, 1);
        do_op("s_ones",  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 6'd31, 1'b0, 1);
        do_op("s_zero",  32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b1, 1);
        do_op("s_neg",   32'hFFFF_8000, 1'b1, 32'h8000_0000, 6'd16, 1'b0, 18);
        do_op("s_max",   32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 6'd0,  1'b0, 2);
        do_op("s_one",   32'h0000_0001, 1'b1, 32'h4000_0000, 6'd30, 1'b0, 32);

        // start during RUN and DONE must be ignored; outputs held meanwhile
        sb.push_back('{norm: 32'h8000_0000, lz: 6'd23, iz: 1'b0, edges: 25});
        launch(32'h0000_0100, 1'b0);
        repeat (4) step();
        check("hold_norm", norm_out, 32'h4000_0000);
        check("hold_lz", 32'(lz_count), 32'd30);
        x = 32'h0000_0001;
        signed_mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("hold_busy", 32'(busy), 32'd1);
        wait_done("ignore");
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignore_done_end", 32'(done), 32'd0);
        check("ignore_no_busy", 32'(busy), 32'd0);
        step();
        check("ignore_still_idle", {30'd0, busy, done}, 32'd0);

        // reset mid-RUN aborts immediately with no done pulse
        launch(32'h0000_0001, 1'b0);
        repeat (4) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_norm", norm_out, 32'd0);
        check("abort_lz", 32'(lz_count), 32'd0);
        check("abort_flags", {29'd0, is_zero, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_done", {30'd0, busy, done}, 32'd0);
        do_op("post_rst", 32'h4000_0000, 1'b0, 32'h8000_0000, 6'd1, 1'b0, 3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
